// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI command path.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUMMY,
    FRAME,
    POLL,
    GAP,
    DONE
  } sd_state_e;

  localparam logic [1:0] SD_START_BITS = 2'b01;
  localparam logic [7:0] SD_IDLE_BYTE  = 8'hFF;
  localparam logic [6:0] CRC7_POLY     = 7'h09;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, zero seed) over a 40-bit command header, MSB first.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  logic fb;

  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_spi_cmd_ctrl.sv
// SD SPI command sequencer: dummy-clock preamble, 6-byte command framing,
// R1 polling with timeout, trailing gap byte, chip-select ownership.
module sd_spi_cmd_ctrl
  import sd_spi_pkg::*;
#(
  parameter int POLL_MAX    = 8,
  parameter int DUMMY_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  output logic [7:0]  rsp_r1,
  output logic        rsp_timeout,
  output logic        init_done,
  output logic        cs_n,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx
);

  localparam logic [7:0] POLL_LAST  = 8'(POLL_MAX - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_BYTES - 1);
  localparam logic [7:0] FRAME_LAST = 8'd5;

  sd_state_e   state_reg, state_next;
  logic        busy_reg, busy_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [47:0] frame_reg, frame_next;
  logic [7:0]  byte_tx_reg, byte_tx_next;
  logic        byte_start_reg, byte_start_next;
  logic        cs_n_reg, cs_n_next;
  logic [7:0]  r1_cap_reg, r1_cap_next;
  logic        to_cap_reg, to_cap_next;
  logic [7:0]  rsp_r1_reg, rsp_r1_next;
  logic        rsp_timeout_reg, rsp_timeout_next;
  logic        init_done_reg, init_done_next;

  logic [6:0]  crc;
  logic [7:0]  frame_byte [0:7];
  logic        accept, issue, done_evt, last_byte;

  assign cmd_ready = (state_reg == IDLE) && !init_req && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign issue     = (state_reg inside {DUMMY, FRAME, POLL, GAP}) && !busy_reg;
  // A byte_done only counts while our own transfer is outstanding.
  assign done_evt  = busy_reg && byte_done;

  sd_crc7 u_crc7 (
    .data ({SD_START_BITS, cmd_idx, cmd_arg}),
    .crc  (crc)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_frame_byte
      if (gi < 6) begin : g_used
        assign frame_byte[gi] = frame_reg[47 - 8*gi -: 8];
      end else begin : g_pad
        assign frame_byte[gi] = SD_IDLE_BYTE;
      end
    end
  endgenerate

  always_comb begin
    case (state_reg)
      DUMMY:   last_byte = (cnt_reg == DUMMY_LAST);
      FRAME:   last_byte = (cnt_reg == FRAME_LAST);
      POLL:    last_byte = !byte_rx[7] || (cnt_reg == POLL_LAST);
      GAP:     last_byte = 1'b1;
      default: last_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (init_req)    state_next = DUMMY;
        else if (accept) state_next = FRAME;
      end
      DUMMY:   if (done_evt && last_byte) state_next = IDLE;
      FRAME:   if (done_evt && last_byte) state_next = POLL;
      POLL:    if (done_evt && last_byte) state_next = GAP;
      GAP:     if (done_evt)              state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next        = busy_reg;
    cnt_next         = cnt_reg;
    frame_next       = frame_reg;
    byte_tx_next     = byte_tx_reg;
    byte_start_next  = 1'b0;
    cs_n_next        = cs_n_reg;
    r1_cap_next      = r1_cap_reg;
    to_cap_next      = to_cap_reg;
    rsp_r1_next      = rsp_r1_reg;
    rsp_timeout_next = rsp_timeout_reg;
    init_done_next   = 1'b0;

    if (accept)
      frame_next = {SD_START_BITS, cmd_idx, cmd_arg, crc, 1'b1};

    if (issue) begin
      byte_start_next = 1'b1;
      busy_next       = 1'b1;
      byte_tx_next    = (state_reg == FRAME) ? frame_byte[cnt_reg[2:0]] : SD_IDLE_BYTE;
      cs_n_next       = !(state_reg inside {FRAME, POLL});
    end

    if (done_evt) begin
      busy_next = 1'b0;
      cnt_next  = last_byte ? 8'd0 : cnt_reg + 8'd1;
      if (last_byte) begin
        case (state_reg)
          DUMMY: init_done_next = 1'b1;
          POLL: begin
            r1_cap_next = byte_rx[7] ? SD_IDLE_BYTE : byte_rx;
            to_cap_next = byte_rx[7];
            cs_n_next   = 1'b1;
          end
          // Response registers only move together with rsp_valid.
          GAP: begin
            rsp_r1_next      = r1_cap_reg;
            rsp_timeout_next = to_cap_reg;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg        <= 1'b0;
      cnt_reg         <= 8'd0;
      frame_reg       <= '0;
      byte_tx_reg     <= SD_IDLE_BYTE;
      byte_start_reg  <= 1'b0;
      cs_n_reg        <= 1'b1;
      r1_cap_reg      <= SD_IDLE_BYTE;
      to_cap_reg      <= 1'b0;
      rsp_r1_reg      <= SD_IDLE_BYTE;
      rsp_timeout_reg <= 1'b0;
      init_done_reg   <= 1'b0;
    end else begin
      busy_reg        <= busy_next;
      cnt_reg         <= cnt_next;
      frame_reg       <= frame_next;
      byte_tx_reg     <= byte_tx_next;
      byte_start_reg  <= byte_start_next;
      cs_n_reg        <= cs_n_next;
      r1_cap_reg      <= r1_cap_next;
      to_cap_reg      <= to_cap_next;
      rsp_r1_reg      <= rsp_r1_next;
      rsp_timeout_reg <= rsp_timeout_next;
      init_done_reg   <= init_done_next;
    end
  end

  assign rsp_valid   = (state_reg == DONE);
  assign rsp_r1      = rsp_r1_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign init_done   = init_done_reg;
  assign cs_n        = cs_n_reg;
  assign byte_start  = byte_start_reg;
  assign byte_tx     = byte_tx_reg;

endmodule

// File: tb/tb_sd_spi_cmd_ctrl.sv
// Randomized bench for sd_spi_cmd_ctrl with a byte-engine model and a
// frame/response reference built from the SD command rules.
module tb_sd_spi_cmd_ctrl;
  import sd_spi_pkg::*;

  localparam int POLL_MAX    = 8;
  localparam int DUMMY_BYTES = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_req = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout, init_done, cs_n, byte_start;
  logic [7:0]  rsp_r1, byte_tx;
  logic        byte_done = 1'b0;
  logic [7:0]  byte_rx = 8'hFF;

  sd_spi_cmd_ctrl #(.POLL_MAX(POLL_MAX), .DUMMY_BYTES(DUMMY_BYTES)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_r1(rsp_r1), .rsp_timeout(rsp_timeout),
    .init_done(init_done), .cs_n(cs_n), .byte_start(byte_start),
    .byte_tx(byte_tx), .byte_done(byte_done), .byte_rx(byte_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // SPI byte engine: logs every started byte, answers from rx_q after a random delay.
  logic [7:0] tx_q[$];
  logic       cs_q[$];
  logic [7:0] rx_q[$];
  logic       eng_busy = 1'b0;
  int         eng_wait = 0;
  int         proto_err = 0;
  logic       spur_req = 1'b0;
  int         last_done_cyc = 0;

  initial forever begin
    @(negedge clk);
    byte_done = 1'b0;
    if (spur_req) begin
      byte_done = 1'b1;
      byte_rx   = 8'h00;
      spur_req  = 1'b0;
    end else if (eng_busy) begin
      if (eng_wait == 0) begin
        byte_done = 1'b1;
        if (rx_q.size() > 0) byte_rx = rx_q.pop_front();
        else                 byte_rx = 8'hFF;
        eng_busy      = 1'b0;
        last_done_cyc = cyc;
      end else begin
        eng_wait--;
      end
    end
    if (byte_start) begin
      if (eng_busy) proto_err++;
      tx_q.push_back(byte_tx);
      cs_q.push_back(cs_n);
      eng_busy = 1'b1;
      eng_wait = $urandom_range(1, 4);
    end
  end

  int rsp_cnt = 0;
  int init_cnt = 0;
  int rsp_cyc = 0;
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
    end
    if (init_done) init_cnt++;
  end

  int last_base = 0;

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int hit,
                         input logic [7:0] r1);
    logic [7:0]  exp_b[$];
    logic        exp_cs[$];
    logic [39:0] hdr;
    logic [7:0]  exp_r1, prev_r1;
    logic        to_exp, got, r1_moved;
    int          npoll, base, rsp0;
    to_exp = (hit >= POLL_MAX);
    npoll  = to_exp ? POLL_MAX : hit + 1;
    exp_r1 = to_exp ? 8'hFF : r1;
    hdr    = {2'b01, idx, arg};
    for (int i = 0; i < 5; i++) exp_b.push_back(hdr[39 - 8*i -: 8]);
    exp_b.push_back({crc7_ref(hdr), 1'b1});
    for (int i = 0; i < npoll + 1; i++) exp_b.push_back(8'hFF);
    for (int i = 0; i < 6 + npoll; i++) exp_cs.push_back(1'b0);
    exp_cs.push_back(1'b1);
    rx_q.delete();
    for (int i = 0; i < 6; i++) rx_q.push_back(8'($urandom));
    for (int k = 0; k < npoll; k++)
      rx_q.push_back((!to_exp && k == hit) ? r1 : (8'($urandom) | 8'h80));
    rx_q.push_back(8'($urandom));

    base = tx_q.size();
    last_base = base;
    rsp0 = rsp_cnt;
    prev_r1 = rsp_r1;
    r1_moved = 1'b0;
    @(negedge clk);
    cmd_idx = idx;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cmd_accept", got, 1);
    got = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (rsp_r1 !== prev_r1) r1_moved = 1'b1;
      cmd_valid = 1'($urandom);
      cmd_idx   = 6'($urandom);
      cmd_arg   = $urandom;
      init_req  = ($urandom_range(0, 7) == 0);
    end
    cmd_valid = 1'b0;
    init_req  = 1'b0;
    check("rsp_seen", got, 1);
    check("rsp_r1_stable_before", r1_moved, 0);
    check("rsp_r1", rsp_r1, exp_r1);
    check("rsp_timeout", rsp_timeout, to_exp);
    @(negedge clk);
    #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("rsp_count", rsp_cnt - rsp0, 1);
    check("rsp_latency", rsp_cyc - last_done_cyc, 1);
    check("ready_after_done", cmd_ready, 1);
    check("rsp_r1_hold", rsp_r1, exp_r1);
    check("tx_count", tx_q.size() - base, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) begin
      if (base + i < tx_q.size()) begin
        check("tx_byte", tx_q[base + i], exp_b[i]);
        check("cs_n_at_start", cs_q[base + i], exp_cs[i]);
      end
    end
    $display("cmd idx=%0d arg=%08h polls=%0d r1=%02h timeout=%0b", idx, arg, npoll, rsp_r1, rsp_timeout);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0, r0;
    logic got;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_byte_start", byte_start, 0);
    check("rst_byte_tx", byte_tx, 8'hFF);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_r1", rsp_r1, 8'hFF);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_init_done", init_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle_ready", cmd_ready, 1);

    // Preamble requested together with a command: init wins.
    @(negedge clk);
    init_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_idx = CMD0;
    cmd_arg = '0;
    #1;
    check("init_priority_ready", cmd_ready, 0);
    @(negedge clk);
    init_req = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (init_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("init_seen", got, 1);
    check("init_ready", cmd_ready, 1);
    check("init_tx_count", tx_q.size(), DUMMY_BYTES);
    for (int i = 0; i < tx_q.size(); i++) begin
      check("init_byte", tx_q[i], 8'hFF);
      check("init_cs_n", cs_q[i], 1);
    end
    @(negedge clk);
    check("init_pulse_once", init_cnt, 1);
    check("init_no_cmd", tx_q.size(), DUMMY_BYTES);
    $display("init bytes=%0d init_done_pulses=%0d", tx_q.size(), init_cnt);

    run_cmd(CMD0, 32'h0000_0000, 1, 8'h01);
    check("cmd0_b0", tx_q[last_base], 8'h40);
    check("cmd0_b5", tx_q[last_base + 5], 8'h95);
    run_cmd(CMD8, 32'h0000_01AA, 0, 8'h01);
    check("cmd8_b0", tx_q[last_base], 8'h48);
    check("cmd8_b4", tx_q[last_base + 4], 8'hAA);
    check("cmd8_b5", tx_q[last_base + 5], 8'h87);
    run_cmd(CMD55, 32'h0000_0000, POLL_MAX, 8'h00);

    // Spurious byte_done while idle must be ignored.
    n0 = tx_q.size();
    r0 = rsp_cnt;
    @(negedge clk);
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("spur_tx_count", tx_q.size(), n0);
    check("spur_rsp_count", rsp_cnt, r0);
    check("spur_cs_n", cs_n, 1);
    check("spur_ready", cmd_ready, 1);
    $display("spurious byte_done in idle: bytes_started=%0d", tx_q.size() - n0);

    // Reset in the middle of frame byte b3.
    rx_q.delete();
    n0 = tx_q.size();
    r0 = rsp_cnt;
    @(negedge clk);
    cmd_idx = CMD17;
    cmd_arg = $urandom;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (tx_q.size() >= n0 + 4) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_b3", got, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_byte_start", byte_start, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("rst_mid_tx_count", tx_q.size(), n0 + 4);
    check("rst_mid_no_rsp", rsp_cnt, r0);
    check("rst_mid_rsp_r1", rsp_r1, 8'hFF);
    check("rst_mid_cs_n_idle", cs_n, 1);
    check("rst_mid_ready", cmd_ready, 1);
    $display("reset mid-frame: bytes_started=%0d rsp_pulses=%0d", tx_q.size() - n0, rsp_cnt - r0);

    run_cmd(CMD24, 32'h1234_5678, 3, 8'h00);
    for (int n = 0; n < 12; n++)
      run_cmd(6'($urandom), $urandom, $urandom_range(0, POLL_MAX + 1), 8'($urandom_range(0, 127)));

    check("one_outstanding", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
